// File: rtl/pc_sequencer_if.sv
// Bundle of the sequencer's fetch, data-memory and decode-side signals.
// master = sequencer side, slave = memory/decoder/environment side.
interface pc_sequencer_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 3;

    logic            stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] ir;
    logic            ir_valid;
    logic            is_mem;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            mem_req;
    logic            mem_ack;
    logic            wb_en;
    logic [XLEN-1:0] pc;
    logic [SW-1:0]   state;
    logic [XLEN-1:0] retired;

    modport master (
        input  stall, imem_ack, imem_rdata, is_mem, branch_taken, branch_target, mem_ack,
        output imem_req, imem_addr, ir, ir_valid, mem_req, wb_en, pc, state, retired
    );

    modport slave (
        output stall, imem_ack, imem_rdata, is_mem, branch_taken, branch_target, mem_ack,
        input  imem_req, imem_addr, ir, ir_valid, mem_req, wb_en, pc, state, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM owning the program counter:
// FETCH -> WAIT_I -> DECODE -> EXEC -> [MEM] -> WB, one instruction at a time.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic           clk,
    input logic           resetn,
    pc_sequencer_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 3;

    localparam logic [SW-1:0] FETCH  = 3'd0;
    localparam logic [SW-1:0] WAIT_I = 3'd1;
    localparam logic [SW-1:0] DECODE = 3'd2;
    localparam logic [SW-1:0] EXEC   = 3'd3;
    localparam logic [SW-1:0] MEM    = 3'd4;
    localparam logic [SW-1:0] WB     = 3'd5;

    logic [SW-1:0]   state_q;
    logic [SW-1:0]   state_d;
    logic            imem_req_q;
    logic            imem_req_d;
    logic            mem_req_q;
    logic            mem_req_d;
    logic            ir_valid_q;
    logic            ir_valid_d;
    logic            wb_en_q;
    logic            wb_en_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] retired_q;

    // State register; strobes are registered from the next state so they
    // line up with the state they belong to without any input-to-output path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            mem_req_q  <= mem_req_d;
            ir_valid_q <= ir_valid_d;
            wb_en_q    <= wb_en_d;
        end
    end

    // Next-state and next-strobe logic; unused codes fall back to FETCH.
    always_comb begin
        state_d    = state_q;
        imem_req_d = 1'b0;
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b0;
        wb_en_d    = 1'b0;

        case (state_q)
            FETCH:   if (!bus.stall) state_d = WAIT_I;
            WAIT_I:  if (bus.imem_ack) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = bus.is_mem ? MEM : WB;
            MEM:     if (bus.mem_ack) state_d = WB;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase

        imem_req_d = (state_d == WAIT_I);
        mem_req_d  = (state_d == MEM);
        ir_valid_d = (state_d == DECODE);
        wb_en_d    = (state_d == WB);
    end

    // Datapath: IR captured on fetch ack, target resolved in EXEC, PC committed in WB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            if ((state_q == WAIT_I) && bus.imem_ack) begin
                ir_q <= bus.imem_rdata;
            end
            if (state_q == EXEC) begin
                pc_next_q <= bus.branch_taken ? (bus.branch_target & ~XLEN'(3))
                                              : (pc_q + PC_STEP);
            end
            if (state_q == WB) begin
                pc_q      <= pc_next_q;
                retired_q <= retired_q + XLEN'(1);
            end
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.pc        = pc_q;
    assign bus.state     = state_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: the driver pushes each instruction's expected
// outcome into a queue; a negedge monitor pops it when wb_en appears and compares.
module tb_pc_sequencer;
    localparam logic [31:0] RST1 = 32'hFFFF_FFFC;

    typedef struct {
        int unsigned s;
        int unsigned di;
        int unsigned dm;
        logic        is_mem;
        logic [31:0] rdata;
        logic [31:0] pc_before;
        logic [31:0] pc_after;
        logic [31:0] ret_after;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();
    pc_sequencer_if bus1 ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    pc_sequencer #(.RESET_PC(RST1), .PC_STEP(32'd4)) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1)
    );

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] m_pc     = 32'h0;
    logic [31:0] m_ret    = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Junk on every input; the DUT must ignore whatever is not sampled in the current state.
    task automatic garbage();
        bus.stall         = rb();
        bus.imem_ack      = rb();
        bus.imem_rdata    = $urandom;
        bus.is_mem        = rb();
        bus.branch_taken  = rb();
        bus.branch_target = $urandom;
        bus.mem_ack       = rb();
    endtask

    task automatic do_reset(input int unsigned n);
        resetn = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            garbage();
            bus.imem_ack = 1'b1;
            bus.mem_ack  = 1'b1;
            step();
        end
        check("rst_pc",       bus.pc,        32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_state",    32'(bus.state), 32'h0);
        check("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check("rst_mem_req",  32'(bus.mem_req),  32'h0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
        check("rst_wb_en",    32'(bus.wb_en),    32'h0);
        check("rst_ir",       bus.ir,        32'h0);
        check("rst_retired",  bus.retired,   32'h0);
        check("rst_pc_dut1",  bus1.pc,       RST1);
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        resetn = 1'b1;
    endtask

    // Open-loop driver for one instruction; starts in the FETCH cycle.
    task automatic run_instr(input int unsigned s, input int unsigned di, input int unsigned dm,
                             input logic im, input logic tk, input logic [31:0] tgt,
                             input logic late_ack);
        exp_t        e;
        logic [31:0] rd;
        rd          = $urandom;
        e.s         = s;
        e.di        = di;
        e.dm        = dm;
        e.is_mem    = im;
        e.rdata     = rd;
        e.pc_before = m_pc;
        e.pc_after  = tk ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        e.ret_after = m_ret + 32'd1;
        exp_q.push_back(e);
        m_pc  = e.pc_after;
        m_ret = e.ret_after;

        for (int unsigned k = 0; k <= s; k++) begin
            garbage();
            bus.stall = (k < s);
            if (late_ack) bus.imem_ack = 1'b1;
            step();
        end
        for (int unsigned k = 0; k <= di; k++) begin
            garbage();
            bus.imem_ack   = (k == di);
            bus.imem_rdata = (k == di) ? rd : $urandom;
            step();
        end
        garbage();
        step();
        garbage();
        bus.is_mem        = im;
        bus.branch_taken  = tk;
        bus.branch_target = tgt;
        step();
        if (im) begin
            for (int unsigned k = 0; k <= dm; k++) begin
                garbage();
                bus.mem_ack = (k == dm);
                step();
            end
        end
        garbage();
        step();
    endtask

    // Start an instruction, abandon it with a reset while it waits for its fetch.
    task automatic abort_in_wait();
        garbage();
        bus.stall = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            garbage();
            bus.imem_ack = 1'b0;
            step();
        end
        do_reset(2);
    endtask

    // Scoreboard monitor for the main instance.
    logic        rst_prev = 1'b0;
    int unsigned fetch_cnt, req_cnt, mem_cnt, iv_cnt, body_cnt;
    logic        wb_pend;
    logic        addr_ok, ir_ok;
    logic [31:0] last_ir;
    exp_t        wexp;

    always @(negedge clk) begin
        if (!rst_prev) begin
            fetch_cnt = 0; req_cnt = 0; mem_cnt = 0; iv_cnt = 0; body_cnt = 0;
            wb_pend = 1'b0; addr_ok = 1'b1; ir_ok = 1'b1; last_ir = 32'h0;
        end
        if (wb_pend) begin
            check("pc_after_wb",      bus.pc,      wexp.pc_after);
            check("retired_after_wb", bus.retired, wexp.ret_after);
            check("wb_en_one_cycle",  32'(bus.wb_en), 32'h0);
            check("state_after_wb",   32'(bus.state), 32'h0);
            wb_pend = 1'b0;
        end
        if (bus.imem_req === 1'b1) begin
            req_cnt++;
            if (exp_q.size() > 0 && bus.imem_addr !== exp_q[0].pc_before) addr_ok = 1'b0;
            if (bus.ir !== last_ir) ir_ok = 1'b0;
        end else if (req_cnt == 0) begin
            fetch_cnt++;
        end
        if (req_cnt > 0) body_cnt++;
        if (bus.mem_req === 1'b1) mem_cnt++;
        if (bus.ir_valid === 1'b1) iv_cnt++;
        if (bus.wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wb_unexpected: wb_en seen with no instruction outstanding");
            end else begin
                wexp = exp_q.pop_front();
                check("ir",          bus.ir, wexp.rdata);
                check("pc_in_wb",    bus.pc, wexp.pc_before);
                check("fetch_cycles", 32'(fetch_cnt), 32'(wexp.s + 1));
                check("imem_req_cycles", 32'(req_cnt), 32'(wexp.di + 1));
                check("mem_req_cycles", 32'(mem_cnt), wexp.is_mem ? 32'(wexp.dm + 1) : 32'h0);
                check("ir_valid_pulses", 32'(iv_cnt), 32'h1);
                check("instr_cycles", 32'(body_cnt),
                      32'(wexp.di + 1 + 2 + (wexp.is_mem ? wexp.dm + 1 : 0) + 1));
                check("imem_addr_stable", 32'(addr_ok), 32'h1);
                check("ir_held_in_wait",  32'(ir_ok),   32'h1);
                last_ir = wexp.rdata;
                wb_pend = 1'b1;
            end
            fetch_cnt = 0; req_cnt = 0; mem_cnt = 0; iv_cnt = 0; body_cnt = 0;
            addr_ok = 1'b1; ir_ok = 1'b1;
        end
        rst_prev = resetn;
    end

    // Second instance free-runs from RESET_PC=0xFFFFFFFC; its PC must wrap to 0.
    logic        rst_prev1 = 1'b0;
    logic        pend1;
    logic [31:0] exp1;

    always @(negedge clk) begin
        if (!rst_prev1) begin
            exp1  = RST1;
            pend1 = 1'b0;
        end else begin
            if (pend1) begin
                exp1 = exp1 + 32'd4;
                check("dut1_pc_after_wb", bus1.pc, exp1);
                pend1 = 1'b0;
            end
            if (bus1.wb_en === 1'b1) pend1 = 1'b1;
        end
        rst_prev1 = resetn;
    end

    initial begin
        bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.is_mem = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 32'h0; bus.mem_ack = 1'b0;
        bus1.stall = 1'b0; bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h0; bus1.is_mem = 1'b0;
        bus1.branch_taken = 1'b0; bus1.branch_target = 32'h0; bus1.mem_ack = 1'b1;

        do_reset(2);

        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_instr(0, 0, 0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        run_instr(0, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_instr(0, 3, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_instr(0, 0, 2, 1'b1, 1'b0, 32'h0, 1'b0);
        run_instr(2, 1, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_instr(1, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

        abort_in_wait();
        run_instr(2, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                      rb(), ($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
